// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - registered ALU execute stage with two-entry skid buffer
module alu_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RA_W-1:0] out_rd,
    output logic            out_illegal
);
    localparam int SHW = $clog2(XLEN);

    // bit0 = main entry valid, bit1 = skid entry valid
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b11;

    logic [1:0]      state;
    logic [XLEN-1:0] m_result, s_result;
    logic [RA_W-1:0] m_rd, s_rd;
    logic            m_illegal, s_illegal;

    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic [SHW-1:0]  shamt;
    logic            accept, drain;

    assign shamt = in_rs2[SHW-1:0];

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (in_op)
            4'b0000: alu_result = in_rs1 + in_rs2;
            4'b1000: alu_result = in_rs1 - in_rs2;
            4'b0001: alu_result = in_rs1 << shamt;
            4'b0010: alu_result = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(in_rs2)};
            4'b0011: alu_result = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
            4'b0100: alu_result = in_rs1 ^ in_rs2;
            4'b0101: alu_result = in_rs1 >> shamt;
            4'b1101: alu_result = $unsigned($signed(in_rs1) >>> shamt);
            4'b0110: alu_result = in_rs1 | in_rs2;
            4'b0111: alu_result = in_rs1 & in_rs2;
            default: alu_illegal = 1'b1;
        endcase
    end

    assign accept = in_valid & ~state[1];
    assign drain  = state[0] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            m_result  <= '0;
            m_rd      <= '0;
            m_illegal <= 1'b0;
            s_result  <= '0;
            s_rd      <= '0;
            s_illegal <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        m_result  <= alu_result;
                        m_rd      <= in_rd;
                        m_illegal <= alu_illegal;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        m_result  <= alu_result;
                        m_rd      <= in_rd;
                        m_illegal <= alu_illegal;
                    end else if (accept) begin
                        state     <= FULL;
                        s_result  <= alu_result;
                        s_rd      <= in_rd;
                        s_illegal <= alu_illegal;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state     <= ONE;
                        m_result  <= s_result;
                        m_rd      <= s_rd;
                        m_illegal <= s_illegal;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign in_ready    = ~state[1];
    assign out_valid   = state[0];
    assign out_result  = m_result;
    assign out_rd      = m_rd;
    assign out_illegal = m_illegal;
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - directed self-checking bench for alu_ex_stage
module tb_alu_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_pass = 0;
    int n_total = 0;
    int n_drained = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    entry_t mq[$];
    bit m_acc, m_drn;

    alu_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic entry_t model_alu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] rd);
        entry_t e;
        int unsigned sh;
        sh = b % 32;
        e.rd = rd;
        e.illegal = 1'b0;
        e.result = 32'd0;
        case (op)
            4'd0:  e.result = a + b;
            4'd8:  e.result = a - b;
            4'd1:  e.result = a << sh;
            4'd2:  e.result = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd3:  e.result = (a < b) ? 32'd1 : 32'd0;
            4'd4:  e.result = a ^ b;
            4'd5:  e.result = a >> sh;
            4'd13: begin
                e.result = a >> sh;
                if (a[31]) e.result = e.result | ~(32'hFFFF_FFFF >> sh);
            end
            4'd6:  e.result = a | b;
            4'd7:  e.result = a & b;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Occupancy model: a FIFO of at most two computed results.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            m_drn = (mq.size() > 0) && out_ready;
            if (m_drn) void'(mq.pop_front());
            if (m_acc) mq.push_back(model_alu(in_op, in_rs1, in_rs2, in_rd));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_out_result", out_result, 32'd0);
        end else begin
            check("cmp_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            check("cmp_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            if (mq.size() > 0 && out_valid) begin
                check("cmp_out_result", out_result, mq[0].result);
                check("cmp_out_rd", {27'd0, out_rd}, {27'd0, mq[0].rd});
                check("cmp_out_illegal", {31'd0, out_illegal}, {31'd0, mq[0].illegal});
            end
            if (out_valid && out_ready) n_drained++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        bit acc;
        acc = 1'b0;
        drive(op, a, b, rd);
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_op = 4'd0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        repeat (3) step();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_rd", {27'd0, out_rd}, 32'd0);
        check("reset_out_illegal", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        step();

        // Ops sweep, one cycle latency each
        out_ready = 1'b1;
        send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd1);
        check("slt_valid", {31'd0, out_valid}, 32'd1);
        check("slt_result", out_result, 32'd1);
        send(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd2);
        check("sltu_result", out_result, 32'd0);
        send(4'b1000, 32'd1, 32'd2, 5'd3);
        check("sub_result", out_result, 32'hFFFF_FFFF);
        send(4'b1101, 32'h8000_0000, 32'h21, 5'd4);
        check("sra_result", out_result, 32'hC000_0000);
        send(4'b1010, 32'd5, 32'd6, 5'd7);
        check("illegal_valid", {31'd0, out_valid}, 32'd1);
        check("illegal_result", out_result, 32'd0);
        check("illegal_flag", {31'd0, out_illegal}, 32'd1);
        check("illegal_rd", {27'd0, out_rd}, 32'd7);
        step();

        // Backpressure
        out_ready = 1'b0;
        drive(4'b0000, 32'd1, 32'd1, 5'd1);
        step();
        drive(4'b0000, 32'd2, 32'd2, 5'd2);
        step();
        drive(4'b0000, 32'd3, 32'd3, 5'd3);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_head", out_result, 32'd2);
        step();
        step();
        check("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_stall_result", out_result, 32'd2);
        out_ready = 1'b1;
        step();
        check("bp_second", out_result, 32'd4);
        check("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_third", out_result, 32'd6);
        in_valid = 1'b0;
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate
        n0 = n_drained;
        for (int i = 0; i < 8; i++) begin
            drive(4'(i % 8), 32'h1234_0000 + 32'(i * 7), 32'(i * 5 + 1), 5'(i + 8));
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        check("stream_count", 32'(n_drained - n0), 32'd8);

        // Flush while full with an op offered
        out_ready = 1'b0;
        drive(4'b0000, 32'd10, 32'd1, 5'd1);
        step();
        drive(4'b0000, 32'd20, 32'd2, 5'd2);
        step();
        drive(4'b0000, 32'd30, 32'd3, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset between edges
        out_ready = 1'b0;
        drive(4'b0000, 32'd7, 32'd7, 5'd9);
        step();
        drive(4'b0000, 32'd8, 32'd8, 5'd10);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out_result", out_result, 32'd0);
        check("async_out_rd", {27'd0, out_rd}, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'b0000, 32'd5, 32'd6, 5'd3);
        check("post_reset_result", out_result, 32'd11);
        check("post_reset_rd", {27'd0, out_rd}, 32'd3);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
